// File: rtl/io_map_pkg.sv
// IO bus address map, master FSM state encoding and shared widths.
// Used by io_bus_master and by the PDU, so the address constants are defined in one place.
package io_map_pkg;

    localparam logic [7:0] ADDR_OUT0  = 8'h00;
    localparam logic [7:0] ADDR_READY = 8'h04;
    localparam logic [7:0] ADDR_OUT1  = 8'h08;
    localparam logic [7:0] ADDR_IN    = 8'h0c;
    localparam logic [7:0] ADDR_VALID = 8'h10;

    localparam int OUT0_W = 5;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_SEED = 4'd1;
    localparam logic [3:0] S_W1   = 4'd2;
    localparam logic [3:0] S_W0   = 4'd3;
    localparam logic [3:0] S_RDY  = 4'd4;
    localparam logic [3:0] S_POLL = 4'd5;
    localparam logic [3:0] S_RD   = 4'd6;
    localparam logic [3:0] S_NRDY = 4'd7;
    localparam logic [3:0] S_UPD  = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE = S_IDLE,
        ST_SEED = S_SEED,
        ST_W1   = S_W1,
        ST_W0   = S_W0,
        ST_RDY  = S_RDY,
        ST_POLL = S_POLL,
        ST_RD   = S_RD,
        ST_NRDY = S_NRDY,
        ST_UPD  = S_UPD
    } state_t;

    // Ones in the low 4*digits bits of the accumulator.
    function automatic logic [31:0] digit_mask(input int digits);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < digits * 4) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/io_poll_debounce.sv
// Stability filter for the valid toggle: reports a change only after DEBOUNCE_CYC
// consecutive enabled samples differ from the reference.
module io_poll_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample,
    input  logic i_sample_en,
    input  logic i_ref,
    output logic o_changed
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] r_stable;
    logic          w_diff;
    logic          w_hit;

    assign w_diff    = i_sample_en && (i_sample != i_ref);
    assign w_hit     = w_diff && (r_stable == CW'(DEBOUNCE_CYC - 1));
    assign o_changed = w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
        end else if (!w_diff || w_hit) begin
            r_stable <= '0;
        end else begin
            r_stable <= r_stable + CW'(1);
        end
    end

endmodule

// File: rtl/io_bus_master.sv
// Hardware IO-bus initiator running the switch/LED hex-entry protocol without a CPU.
// Optional input filtering on the valid toggle is enabled with IO_MASTER_DEBOUNCE_EN.
module io_bus_master
    import io_map_pkg::*;
#(
    parameter int MAX_DIGITS = 8
`ifdef IO_MASTER_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYC = 4
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    input  logic [31:0] io_din,
    output logic        busy,
    output logic [15:0] events
);

    localparam logic [31:0]       LP_ACC_MASK = digit_mask(MAX_DIGITS);
    localparam logic [OUT0_W-1:0] LP_MAX_CNT  = OUT0_W'(MAX_DIGITS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_acc;
    logic [OUT0_W-1:0] r_cnt;
    logic              r_last_valid;
    logic [4:0]        r_sw;
    logic [15:0]       r_events;

    logic [7:0]        w_addr;
    logic [31:0]       w_dout;
    logic              w_we;
    logic              w_changed;
    logic              w_in_poll;
    logic              w_unused_din;

    assign w_in_poll    = (r_state == ST_POLL);
    assign w_unused_din = ^io_din[31:5];

`ifdef IO_MASTER_DEBOUNCE_EN
    io_poll_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .i_sample    (io_din[0]),
        .i_sample_en (w_in_poll),
        .i_ref       (r_last_valid),
        .o_changed   (w_changed)
    );
`else
    assign w_changed = w_in_poll && (io_din[0] != r_last_valid);
`endif

    // NOTE: non-blocking assignments, so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_last_valid <= 1'b0;
            r_sw         <= '0;
            r_events     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_SEED: r_last_valid <= io_din[0];
                ST_RD: begin
                    r_sw         <= io_din[4:0];
                    r_last_valid <= ~r_last_valid;
                    r_events     <= r_events + 16'd1;
                end
                ST_UPD: begin
                    if (r_sw[4]) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_acc <= {r_acc[27:0], r_sw[3:0]} & LP_ACC_MASK;
                        r_cnt <= (r_cnt >= LP_MAX_CNT) ? LP_MAX_CNT : r_cnt + OUT0_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr      = '0;
        w_dout      = '0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: if (start && !stop) w_state_nxt = ST_SEED;
            ST_SEED: begin
                w_addr      = ADDR_VALID;
                w_state_nxt = ST_W1;
            end
            ST_W1: begin
                w_addr      = ADDR_OUT1;
                w_we        = 1'b1;
                w_dout      = r_acc;
                w_state_nxt = ST_W0;
            end
            ST_W0: begin
                w_addr      = ADDR_OUT0;
                w_we        = 1'b1;
                w_dout      = {{(32-OUT0_W){1'b0}}, r_cnt};
                w_state_nxt = ST_RDY;
            end
            ST_RDY: begin
                w_addr      = ADDR_READY;
                w_we        = 1'b1;
                w_dout      = 32'd1;
                w_state_nxt = ST_POLL;
            end
            ST_POLL: begin
                w_addr = ADDR_VALID;
                if (stop)           w_state_nxt = ST_IDLE;
                else if (w_changed) w_state_nxt = ST_RD;
            end
            ST_RD: begin
                w_addr      = ADDR_IN;
                w_state_nxt = ST_NRDY;
            end
            ST_NRDY: begin
                w_addr      = ADDR_READY;
                w_we        = 1'b1;
                w_state_nxt = ST_UPD;
            end
            ST_UPD:  w_state_nxt = ST_W1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign io_addr = w_addr;
    assign io_dout = w_dout;
    assign io_we   = w_we;
    assign busy    = (r_state != ST_IDLE);
    assign events  = r_events;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: bus writes are checked against a scoreboard of
// expected (address, data) pairs pushed when each stimulus step is driven.
module tb_io_bus_master;
    import io_map_pkg::*;

`ifdef IO_MASTER_DEBOUNCE_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic [31:0] io_din;
    logic        busy;
    logic [15:0] events;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        sw_valid;
    logic [4:0]  sw_in;
    logic [31:0] m_acc;
    logic [4:0]  m_cnt;
    logic [15:0] m_events;
    logic [31:0] obs_out1;
    logic [31:0] obs_out0;

    io_bus_master dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .io_we   (io_we),
        .io_din  (io_din),
        .busy    (busy),
        .events  (events)
    );

    always #5 clk = ~clk;

    // Switch board model; junk in the upper bits of the switch word must be ignored.
    always_comb begin
        io_din = '0;
        if (io_addr == ADDR_VALID)   io_din = {31'd0, sw_valid};
        else if (io_addr == ADDR_IN) io_din = {27'h2ABCDEF, sw_in};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (io_we) begin
            if (io_addr == ADDR_OUT1) obs_out1 = io_dout;
            if (io_addr == ADDR_OUT0) obs_out0 = io_dout;
            if (sb_q.size() == 0) begin
                check("unexpected_write", {24'd0, io_addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", {24'd0, io_addr}, {24'd0, e.addr});
                check("wr_data", io_dout, e.data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic model_digit(input logic [4:0] d);
        if (d[4]) begin
            m_acc = '0;
            m_cnt = '0;
        end else begin
            m_acc = {m_acc[27:0], d[3:0]};
            m_cnt = (m_cnt < 5'd8) ? m_cnt + 5'd1 : 5'd8;
        end
        m_events = m_events + 16'd1;
        push(ADDR_READY, 32'd0);
        push(ADDR_OUT1, m_acc);
        push(ADDR_OUT0, {27'd0, m_cnt});
        push(ADDR_READY, 32'd1);
    endtask

    task automatic wait_poll(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (sb_q.size() == 0 && busy && io_addr == ADDR_VALID && !io_we) found = 1'b1;
            else step(1);
        end
        if (!found) check({tag, "_poll_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_nrdy(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(1);
            found = io_we && io_addr == ADDR_READY && io_dout == 32'd0;
        end
        if (!found) check({tag, "_nrdy_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_event(input logic [4:0] d);
        int k;
        bit seen;
        model_digit(d);
        sw_in    = d;
        sw_valid = ~sw_valid;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < LAT + 4) begin
            step(1);
            k++;
            seen = io_we && io_addr == ADDR_OUT1;
        end
        check("out1_latency", seen ? k : 0, LAT);
        wait_poll("event");
        check("events", {16'd0, events}, {16'd0, m_events});
    endtask

    task automatic start_session(input string tag);
        push(ADDR_OUT1, m_acc);
        push(ADDR_OUT0, {27'd0, m_cnt});
        push(ADDR_READY, 32'd1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_poll(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        sw_valid = 1'b0;
        sw_in    = '0;
        m_acc    = '0;
        m_cnt    = '0;
        m_events = '0;
        obs_out1 = 32'hDEAD_BEEF;
        obs_out0 = 32'hDEAD_BEEF;

        // T1: reset state, then a session publishes out1, out0, ready and polls.
        step(2);
        rst = 1'b0;
        check("rst_addr", {24'd0, io_addr}, 32'd0);
        check("rst_dout", io_dout, 32'd0);
        check("rst_we", {31'd0, io_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_events", {16'd0, events}, 32'd0);
        start_session("t1");
        step(3);
        check("t1_poll_addr", {24'd0, io_addr}, 32'h10);
        check("t1_busy", {31'd0, busy}, 32'd1);

        // T2: one digit.
        do_event(5'h0A);
        check("t2_out1", obs_out1, 32'h0000_000A);
        check("t2_out0", obs_out0, 32'd1);

        // T3: nine digits saturate the count and shift out the oldest.
        for (int d = 1; d <= 9; d++) do_event(5'(d));
        check("t3_out1", obs_out1, 32'h2345_6789);
        check("t3_out0", obs_out0, 32'd8);

        // T4: clear command.
        do_event(5'h10);
        check("t4_out1", obs_out1, 32'd0);
        check("t4_out0", obs_out0, 32'd0);

        // T5: stop raised in NRDY is held off until the next POLL.
        model_digit(5'h03);
        sw_in    = 5'h03;
        sw_valid = ~sw_valid;
        wait_nrdy("t5");
        stop = 1'b1;
        wait_poll("t5");
        check("t5_poll_busy", {31'd0, busy}, 32'd1);
        step(1);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_addr", {24'd0, io_addr}, 32'd0);
        start = 1'b1;
        step(3);
        check("t5_start_stop_idle", {31'd0, busy}, 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        check("t5_events", {16'd0, events}, {16'd0, m_events});

        // T6: reset in the middle of the out1 write.
        push(ADDR_OUT1, m_acc);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("t6_in_w1", {31'd0, io_we}, 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_we", {31'd0, io_we}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_events", {16'd0, events}, 32'd0);
        m_acc    = '0;
        m_cnt    = '0;
        m_events = '0;

        // Valid flipped while idle: seeding must absorb it.
        sw_valid = ~sw_valid;
        start_session("t6");
        step(3);
        check("t6_no_spurious", {16'd0, events}, 32'd0);
        check("t6_acc_cleared", obs_out1, 32'd0);

        // A toggle inside RD..RDY is picked up at the next POLL.
        model_digit(5'h07);
        sw_in    = 5'h07;
        sw_valid = ~sw_valid;
        wait_nrdy("t6w");
        model_digit(5'h0B);
        sw_in    = 5'h0B;
        sw_valid = ~sw_valid;
        wait_poll("t6w");
        check("t6_window_events", {16'd0, events}, 32'd2);
        check("t6_window_out1", obs_out1, 32'h0000_007B);

`ifdef IO_MASTER_DEBOUNCE_EN
        // Three-cycle glitch is filtered; a held change is accepted once.
        sw_valid = ~sw_valid;
        step(3);
        sw_valid = ~sw_valid;
        step(8);
        check("deb_glitch_events", {16'd0, events}, {16'd0, m_events});
        do_event(5'h0C);
        step(8);
        check("deb_one_event", {16'd0, events}, {16'd0, m_events});
`endif

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
